// File: rtl/rvfi_retire_checker.sv
// RVFI retirement-stream checker: order continuity, PC continuity and channel contiguity.
// Optional macro RVFI_CHECK_INTR_EN adds rvfi_intr, which exempts trap-entry retirements from the PC check.
module rvfi_retire_checker #(
  parameter int NRET  = 1,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                       g_clk,
  input  logic                       g_reset,
  input  logic [NRET-1:0]            rvfi_valid,
  input  logic [64*NRET-1:0]         rvfi_order,
  input  logic [ILEN*NRET-1:0]       rvfi_insn,
  input  logic [XLEN*NRET-1:0]       rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]       rvfi_pc_wdata,
`ifdef RVFI_CHECK_INTR_EN
  input  logic [NRET-1:0]            rvfi_intr,
`endif
  input  logic                       chk_clear,
  output logic                       chk_error,
  output logic [1:0]                 chk_code,
  output logic [$clog2(NRET):0]      chk_channel,
  output logic [ILEN-1:0]            chk_bad_insn,
  output logic [CNT_W-1:0]           chk_retired,
  output logic [1:0]                 chk_state
);

  localparam int CH_W = $clog2(NRET) + 1;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    TRACK      = 2'd1,
    FAILED     = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       exp_order_q, exp_order_d;
  logic [XLEN-1:0]   exp_pc_q, exp_pc_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic [CH_W-1:0]   channel_q, channel_d;
  logic [ILEN-1:0]   bad_insn_q, bad_insn_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  // Serial chain scratch: each channel sees the expectation left by the lower ones.
  logic [63:0]       ord_c;
  logic [XLEN-1:0]   pc_c;
  logic              err_c, hole_c, seeded_c, skip_pc_c;
  logic [1:0]        code_c;
  logic [CH_W-1:0]   ch_c;
  logic [ILEN-1:0]   insn_c;
  logic [CNT_W-1:0]  acc_c;

  always_comb begin
    ord_c     = exp_order_q;
    pc_c      = exp_pc_q;
    err_c     = 1'b0;
    hole_c    = 1'b0;
    seeded_c  = (state_q == TRACK);
    skip_pc_c = 1'b0;
    code_c    = 2'd0;
    ch_c      = '0;
    insn_c    = '0;
    acc_c     = '0;
    for (int i = 0; i < NRET; i++) begin
`ifdef RVFI_CHECK_INTR_EN
      skip_pc_c = rvfi_intr[i];
`else
      skip_pc_c = 1'b0;
`endif
      if (!err_c) begin
        if (!rvfi_valid[i]) begin
          hole_c = 1'b1;
        end else if (hole_c) begin
          err_c  = 1'b1;
          code_c = 2'd1;
          ch_c   = CH_W'(i);
          insn_c = rvfi_insn[i*ILEN +: ILEN];
        end else if (!seeded_c) begin
          // First retirement after reset/clear is trusted and seeds the expectation.
          ord_c    = rvfi_order[i*64 +: 64] + 64'd1;
          pc_c     = rvfi_pc_wdata[i*XLEN +: XLEN];
          seeded_c = 1'b1;
          acc_c    = acc_c + CNT_W'(1);
        end else if (rvfi_order[i*64 +: 64] != ord_c) begin
          err_c  = 1'b1;
          code_c = 2'd2;
          ch_c   = CH_W'(i);
          insn_c = rvfi_insn[i*ILEN +: ILEN];
        end else if (!skip_pc_c && (rvfi_pc_rdata[i*XLEN +: XLEN] != pc_c)) begin
          err_c  = 1'b1;
          code_c = 2'd3;
          ch_c   = CH_W'(i);
          insn_c = rvfi_insn[i*ILEN +: ILEN];
        end else begin
          ord_c = rvfi_order[i*64 +: 64] + 64'd1;
          pc_c  = rvfi_pc_wdata[i*XLEN +: XLEN];
          acc_c = acc_c + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    exp_order_d = exp_order_q;
    exp_pc_d    = exp_pc_q;
    error_d     = error_q;
    code_d      = code_q;
    channel_d   = channel_q;
    bad_insn_d  = bad_insn_q;
    retired_d   = retired_q;
    if (chk_clear) begin
      state_d     = WAIT_FIRST;
      exp_order_d = '0;
      exp_pc_d    = '0;
      error_d     = 1'b0;
      code_d      = 2'd0;
      channel_d   = '0;
      bad_insn_d  = '0;
      retired_d   = '0;
    end else if (state_q != FAILED) begin
      exp_order_d = ord_c;
      exp_pc_d    = pc_c;
      retired_d   = retired_q + acc_c;
      if (err_c) begin
        state_d    = FAILED;
        error_d    = 1'b1;
        code_d     = code_c;
        channel_d  = ch_c;
        bad_insn_d = insn_c;
      end else if (acc_c != '0) begin
        state_d = TRACK;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= WAIT_FIRST;
      exp_order_q <= '0;
      exp_pc_q    <= '0;
      error_q     <= 1'b0;
      code_q      <= 2'd0;
      channel_q   <= '0;
      bad_insn_q  <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_order_q <= exp_order_d;
      exp_pc_q    <= exp_pc_d;
      error_q     <= error_d;
      code_q      <= code_d;
      channel_q   <= channel_d;
      bad_insn_q  <= bad_insn_d;
      retired_q   <= retired_d;
    end
  end

  assign chk_error    = error_q;
  assign chk_code     = code_q;
  assign chk_channel  = channel_q;
  assign chk_bad_insn = bad_insn_q;
  assign chk_retired  = retired_q;
  assign chk_state    = state_q;

endmodule

// File: tb/tb_rvfi_retire_checker.sv
// Directed-vector bench for rvfi_retire_checker with two retire channels.
module tb_rvfi_retire_checker;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  g_reset;
  logic [NRET-1:0]       rvfi_valid;
  logic [64*NRET-1:0]    rvfi_order;
  logic [ILEN*NRET-1:0]  rvfi_insn;
  logic [XLEN*NRET-1:0]  rvfi_pc_rdata;
  logic [XLEN*NRET-1:0]  rvfi_pc_wdata;
  logic [NRET-1:0]       rvfi_intr;
  logic                  chk_clear;
  logic                  chk_error;
  logic [1:0]            chk_code;
  logic [1:0]            chk_channel;
  logic [ILEN-1:0]       chk_bad_insn;
  logic [CNT_W-1:0]      chk_retired;
  logic [1:0]            chk_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rvfi_retire_checker #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .CNT_W(CNT_W)) dut (
    .g_clk        (clk),
    .g_reset      (g_reset),
    .rvfi_valid   (rvfi_valid),
    .rvfi_order   (rvfi_order),
    .rvfi_insn    (rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata),
`ifdef RVFI_CHECK_INTR_EN
    .rvfi_intr    (rvfi_intr),
`endif
    .chk_clear    (chk_clear),
    .chk_error    (chk_error),
    .chk_code     (chk_code),
    .chk_channel  (chk_channel),
    .chk_bad_insn (chk_bad_insn),
    .chk_retired  (chk_retired),
    .chk_state    (chk_state)
  );

  typedef struct {
    logic        clr;
    logic [1:0]  valid;
    logic [1:0]  intr;
    logic [63:0] o0, o1;
    logic [31:0] r0, w0, r1, w1;
    logic [31:0] i0, i1;
    logic        e_err;
    logic [1:0]  e_code;
    logic [1:0]  e_ch;
    logic [31:0] e_insn;
    logic [15:0] e_ret;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic clr, input logic [1:0] valid, input logic [1:0] intr,
                      input logic [63:0] o0, input logic [63:0] o1,
                      input logic [31:0] r0, input logic [31:0] w0,
                      input logic [31:0] r1, input logic [31:0] w1,
                      input logic [31:0] i0, input logic [31:0] i1,
                      input logic e_err, input logic [1:0] e_code, input logic [1:0] e_ch,
                      input logic [31:0] e_insn, input logic [15:0] e_ret, input logic [1:0] e_st);
    vec_t v;
    v.clr = clr; v.valid = valid; v.intr = intr; v.o0 = o0; v.o1 = o1;
    v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.i0 = i0; v.i1 = i1;
    v.e_err = e_err; v.e_code = e_code; v.e_ch = e_ch; v.e_insn = e_insn;
    v.e_ret = e_ret; v.e_st = e_st;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic rst, input logic clr, input logic [1:0] valid, input logic [1:0] intr,
                       input logic [63:0] o0, input logic [63:0] o1,
                       input logic [31:0] r0, input logic [31:0] w0,
                       input logic [31:0] r1, input logic [31:0] w1,
                       input logic [31:0] i0, input logic [31:0] i1);
    @(negedge clk);
    g_reset       = rst;
    chk_clear     = clr;
    rvfi_valid    = valid;
    rvfi_intr     = intr;
    rvfi_order    = {o1, o0};
    rvfi_pc_rdata = {r1, r0};
    rvfi_pc_wdata = {w1, w0};
    rvfi_insn     = {i1, i0};
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_err, input logic [1:0] e_code,
                            input logic [1:0] e_ch, input logic [31:0] e_insn,
                            input logic [15:0] e_ret, input logic [1:0] e_st);
    chk({tag, ".error"},   64'(chk_error),    64'(e_err));
    chk({tag, ".code"},    64'(chk_code),     64'(e_code));
    chk({tag, ".channel"}, 64'(chk_channel),  64'(e_ch));
    chk({tag, ".insn"},    64'(chk_bad_insn), 64'(e_insn));
    chk({tag, ".retired"}, 64'(chk_retired),  64'(e_ret));
    chk({tag, ".state"},   64'(chk_state),    64'(e_st));
  endtask

  initial begin
    // Seeding and same-cycle chaining over two channels.
    addv(0, 2'b01, 0, 5, 0, 32'h100, 32'h104, 0, 0, 32'h13, 0,          0, 0, 0, 0, 1, 1);
    addv(0, 2'b01, 0, 6, 0, 32'h104, 32'h108, 0, 0, 32'h13, 0,          0, 0, 0, 0, 2, 1);
    addv(0, 2'b00, 0, 77, 77, 32'hdead, 0, 32'hbeef, 0, 0, 0,           0, 0, 0, 0, 2, 1);
    addv(0, 2'b11, 0, 7, 8, 32'h108, 32'h10c, 32'h10c, 32'h110, 1, 2,   0, 0, 0, 0, 4, 1);
    // Order mismatch, then frozen.
    addv(0, 2'b01, 0, 10, 0, 32'h110, 32'h114, 0, 0, 32'hdead0001, 0,   1, 2, 0, 32'hdead0001, 4, 2);
    addv(0, 2'b11, 0, 9, 10, 32'h110, 32'h114, 32'h114, 32'h118, 5, 6,  1, 2, 0, 32'hdead0001, 4, 2);
    addv(1, 2'b01, 0, 3, 0, 32'h0, 32'h4, 0, 0, 7, 0,                   0, 0, 0, 0, 0, 0);
    // Gap in TRACK.
    addv(0, 2'b01, 0, 0, 0, 32'h200, 32'h204, 0, 0, 1, 0,               0, 0, 0, 0, 1, 1);
    addv(0, 2'b10, 0, 0, 1, 0, 0, 32'h204, 32'h208, 0, 32'hbad00002,    1, 1, 1, 32'hbad00002, 1, 2);
    addv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0);
    // Seed on ch0 then PC break on ch1 in the same cycle.
    addv(0, 2'b11, 0, 20, 21, 32'h200, 32'h204, 32'h208, 32'h20c, 1, 32'hbad00003, 1, 3, 1, 32'hbad00003, 1, 2);
    addv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0);
    // Clear coincident with an order error.
    addv(0, 2'b01, 0, 5, 0, 32'h100, 32'h104, 0, 0, 1, 0,               0, 0, 0, 0, 1, 1);
    addv(1, 2'b01, 0, 7, 0, 32'h104, 32'h108, 0, 0, 2, 0,               0, 0, 0, 0, 0, 0);
    // Trap-entry retirement.
    addv(0, 2'b01, 0, 0, 0, 32'h100, 32'h104, 0, 0, 1, 0,               0, 0, 0, 0, 1, 1);
`ifdef RVFI_CHECK_INTR_EN
    addv(0, 2'b01, 2'b01, 1, 0, 32'h300, 32'h304, 0, 0, 32'h30200073, 0, 0, 0, 0, 0, 2, 1);
    addv(0, 2'b01, 0, 2, 0, 32'h304, 32'h308, 0, 0, 3, 0,               0, 0, 0, 0, 3, 1);
`else
    addv(0, 2'b01, 2'b01, 1, 0, 32'h300, 32'h304, 0, 0, 32'h30200073, 0, 1, 3, 0, 32'h30200073, 1, 2);
    addv(0, 2'b01, 0, 2, 0, 32'h304, 32'h308, 0, 0, 3, 0,               1, 3, 0, 32'h30200073, 1, 2);
`endif
    addv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0);
    // Gap straight out of WAIT_FIRST.
    addv(0, 2'b10, 0, 0, 4, 0, 0, 32'h500, 32'h504, 0, 32'hbad00004,    1, 1, 1, 32'hbad00004, 0, 2);
    addv(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0,                           0, 0, 0, 0, 0, 0);

    g_reset = 1'b1; chk_clear = 1'b0; rvfi_valid = '0; rvfi_intr = '0;
    rvfi_order = '0; rvfi_insn = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    drive(1, 0, 2'b01, 0, 9, 0, 32'h40, 32'h44, 0, 0, 32'h55, 0);
    drive(1, 1, 2'b01, 0, 9, 0, 32'h40, 32'h44, 0, 0, 32'h55, 0);
    expect_out("reset", 0, 0, 0, 0, 0, 0);

    foreach (vq[k]) begin
      drive(0, vq[k].clr, vq[k].valid, vq[k].intr, vq[k].o0, vq[k].o1,
            vq[k].r0, vq[k].w0, vq[k].r1, vq[k].w1, vq[k].i0, vq[k].i1);
      expect_out($sformatf("vec%0d", k), vq[k].e_err, vq[k].e_code, vq[k].e_ch,
                 vq[k].e_insn, vq[k].e_ret, vq[k].e_st);
    end

    // Reset mid-stream discards the retirement presented with it.
    drive(0, 0, 2'b01, 0, 40, 0, 32'h400, 32'h404, 0, 0, 1, 0);
    expect_out("pre_rst", 0, 0, 0, 0, 1, 1);
    drive(1, 0, 2'b01, 0, 41, 0, 32'h404, 32'h408, 0, 0, 2, 0);
    expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
    // After reset the next retirement is a fresh seed, then checking resumes against it.
    drive(0, 0, 2'b01, 0, 99, 0, 32'h900, 32'h904, 0, 0, 3, 0);
    expect_out("reseed", 0, 0, 0, 0, 1, 1);
    drive(0, 0, 2'b11, 0, 100, 101, 32'h904, 32'h908, 32'h90c, 32'h910, 4, 32'hbad00005);
    expect_out("pc_ch1", 1, 3, 1, 32'hbad00005, 2, 2);
    // Reset also exits FAILED.
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("fail_rst", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
